// File: rtl/pc_ras.sv
// pc_ras: fetch-stage program counter with an integrated return-address stack.
// Supports sequential increment, relative branch, absolute jump, absolute and
// relative call (push link address) and return (pop link address). The stack
// is a circular buffer; pushing when full overwrites the oldest entry. Stack
// overflow and underflow are reported through sticky flags.
module pc_ras #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] START_ADDR = '0,
  parameter int unsigned      INCREMENT  = 4,
  parameter int unsigned      RAS_DEPTH  = 8
) (
  input  logic                         iClk,
  input  logic                         nRst,
  input  logic                         iEn,
  input  logic [2:0]                   iMode,
  input  logic [WIDTH-1:0]             iLoad,
  input  logic [WIDTH-1:0]             iOffset,
  input  logic                         iClrErr,
  output logic [WIDTH-1:0]             oPC,
  output logic [WIDTH-1:0]             oPC_tmp,
  output logic [WIDTH-1:0]             oRetAddr,
  output logic [$clog2(RAS_DEPTH):0]   oDepth,
  output logic                         oEmpty,
  output logic                         oFull,
  output logic                         oOverflow,
  output logic                         oUnderflow
);

  localparam int unsigned PtrW   = $clog2(RAS_DEPTH);
  localparam int unsigned DepthW = PtrW + 1;

  typedef enum logic [2:0] {
    ModeInc     = 3'd0,
    ModeBranch  = 3'd1,
    ModeJump    = 3'd2,
    ModeCall    = 3'd3,
    ModeCallRel = 3'd4,
    ModeRet     = 3'd5
  } mode_e;

  // Registered state
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  tmp_q, tmp_d;
  logic [WIDTH-1:0]  stack_q [RAS_DEPTH];
  logic [PtrW-1:0]   wp_q, wp_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  // Datapath and decoded controls
  logic [WIDTH-1:0]  seq_sum;
  logic [WIDTH-1:0]  rel_sum;
  logic [PtrW-1:0]   top_idx;
  logic [WIDTH-1:0]  top_entry;
  logic              stk_empty;
  logic              stk_full;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;

  assign seq_sum   = pc_q + WIDTH'(INCREMENT);
  assign rel_sum   = pc_q + iOffset;
  // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
  assign top_idx   = wp_q - PtrW'(1);
  assign top_entry = stack_q[top_idx];
  assign stk_empty = (depth_q == '0);
  assign stk_full  = (depth_q == DepthW'(RAS_DEPTH));

  // Decode the operation into PC/tmp next values and stack controls.
  always_comb begin
    pc_d    = pc_q;
    tmp_d   = tmp_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (iEn) begin
      case (iMode)
        ModeBranch: begin
          pc_d  = rel_sum;
          tmp_d = rel_sum;
        end
        ModeJump: begin
          pc_d  = iLoad;
          tmp_d = seq_sum;
        end
        ModeCall: begin
          pc_d    = iLoad;
          tmp_d   = seq_sum;
          push    = 1'b1;
          ovf_set = stk_full;
        end
        ModeCallRel: begin
          pc_d    = rel_sum;
          tmp_d   = rel_sum;
          push    = 1'b1;
          ovf_set = stk_full;
        end
        ModeRet: begin
          tmp_d = seq_sum;
          if (stk_empty) begin
            // Fall through on underflow rather than jumping to a stale entry.
            pc_d    = seq_sum;
            unf_set = 1'b1;
          end else begin
            pc_d = top_entry;
            pop  = 1'b1;
          end
        end
        // INC and the reserved codes: advance only, tmp untouched.
        default: pc_d = seq_sum;
      endcase
    end
  end

  // Pointer, depth and sticky-flag next state; a set event beats a clear.
  always_comb begin
    wp_d    = wp_q;
    depth_d = depth_q;
    if (push) begin
      wp_d = wp_q + PtrW'(1);
      if (!stk_full) depth_d = depth_q + DepthW'(1);
    end else if (pop) begin
      wp_d    = top_idx;
      depth_d = depth_q - DepthW'(1);
    end
    ovf_d = (iClrErr ? 1'b0 : ovf_q) | ovf_set;
    unf_d = (iClrErr ? 1'b0 : unf_q) | unf_set;
  end

  // Control-state registers with asynchronous reset.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      pc_q    <= START_ADDR;
      tmp_q   <= '0;
      wp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      tmp_q   <= tmp_d;
      wp_q    <= wp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage; entries are cleared on reset so a read never returns X.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (push) begin
      stack_q[wp_q] <= seq_sum;
    end
  end

  assign oPC        = pc_q;
  assign oPC_tmp    = tmp_q;
  assign oRetAddr   = stk_empty ? '0 : top_entry;
  assign oDepth     = depth_q;
  assign oEmpty     = stk_empty;
  assign oFull      = stk_full;
  assign oOverflow  = ovf_q;
  assign oUnderflow = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Testbench for pc_ras: directed scenarios followed by randomized operations,
// all checked against a queue-based reference model of the PC and stack.
module tb_pc_ras;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] START = 32'h100;

  localparam logic [2:0] INC = 3'd0, BRANCH = 3'd1, JUMP = 3'd2, CALL = 3'd3;
  localparam logic [2:0] CALLREL = 3'd4, RET = 3'd5;

  logic          iClk = 1'b0;
  logic          nRst = 1'b0;
  logic          iEn = 1'b0;
  logic [2:0]    iMode = 3'd0;
  logic [31:0]   iLoad = '0;
  logic [31:0]   iOffset = '0;
  logic          iClrErr = 1'b0;
  logic [31:0]   oPC, oPC_tmp, oRetAddr;
  logic [2:0]    oDepth;
  logic          oEmpty, oFull, oOverflow, oUnderflow;

  pc_ras #(
    .WIDTH     (W),
    .START_ADDR(START),
    .INCREMENT (4),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .iClk      (iClk),
    .nRst      (nRst),
    .iEn       (iEn),
    .iMode     (iMode),
    .iLoad     (iLoad),
    .iOffset   (iOffset),
    .iClrErr   (iClrErr),
    .oPC       (oPC),
    .oPC_tmp   (oPC_tmp),
    .oRetAddr  (oRetAddr),
    .oDepth    (oDepth),
    .oEmpty    (oEmpty),
    .oFull     (oFull),
    .oOverflow (oOverflow),
    .oUnderflow(oUnderflow)
  );

  always #5 iClk = ~iClk;

  int total = 0;
  int bad   = 0;

  // Reference model: PC, tmp, flags and a bounded LIFO of link addresses.
  logic [31:0] m_pc, m_tmp;
  logic        m_ovf, m_unf;
  logic [31:0] m_stk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = START;
    m_tmp = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_push(input logic [31:0] a);
    m_stk.push_back(a);
    if (m_stk.size() > DEPTH) begin
      void'(m_stk.pop_front());
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_step(input logic en, input logic [2:0] mode, input logic [31:0] load,
                            input logic [31:0] off, input logic clr);
    logic [31:0] seq, rel;
    seq = m_pc + 32'd4;
    rel = m_pc + off;
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (en) begin
      case (mode)
        BRANCH:  begin m_pc = rel;  m_tmp = rel; end
        JUMP:    begin m_pc = load; m_tmp = seq; end
        CALL:    begin model_push(seq); m_pc = load; m_tmp = seq; end
        CALLREL: begin model_push(seq); m_pc = rel; m_tmp = rel; end
        RET: begin
          m_tmp = seq;
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin
            m_pc  = seq;
            m_unf = 1'b1;
          end
        end
        default: m_pc = seq;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_ret;
    exp_ret = (m_stk.size() > 0) ? m_stk[m_stk.size() - 1] : 32'd0;
    chk({tag, ".pc"}, oPC, m_pc);
    chk({tag, ".tmp"}, oPC_tmp, m_tmp);
    chk({tag, ".ret"}, oRetAddr, exp_ret);
    chk({tag, ".depth"}, 32'(oDepth), 32'(m_stk.size()));
    chk({tag, ".empty"}, 32'(oEmpty), 32'(m_stk.size() == 0));
    chk({tag, ".full"}, 32'(oFull), 32'(m_stk.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(oOverflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(oUnderflow), 32'(m_unf));
  endtask

  // Apply one operation across a clock edge, then compare against the model.
  task automatic op(input string tag, input logic en, input logic [2:0] mode,
                    input logic [31:0] load, input logic [31:0] off, input logic clr);
    iEn     = en;
    iMode   = mode;
    iLoad   = load;
    iOffset = off;
    iClrErr = clr;
    @(posedge iClk);
    #1;
    model_step(en, mode, load, off, clr);
    check_all(tag);
  endtask

  logic [31:0] saved_pc, saved_ret;
  logic [2:0]  saved_depth;

  initial begin
    model_reset();
    #12;
    check_all("reset");
    chk("reset.pc_const", oPC, 32'h100);
    @(negedge iClk);
    nRst = 1'b1;

    // Sequential increments, then an asynchronous reset mid-cycle
    op("inc1", 1, INC, 0, 0, 0);
    chk("inc1.const", oPC, 32'h104);
    op("inc2", 1, INC, 0, 0, 0);
    op("inc3", 1, INC, 0, 0, 0);
    chk("inc3.const", oPC, 32'h10C);
    #2;
    nRst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.const", oPC, 32'h100);
    @(negedge iClk);
    nRst = 1'b1;

    // Call and return
    op("jmp200", 1, JUMP, 32'h200, 0, 0);
    op("call", 1, CALL, 32'h800, 0, 0);
    chk("call.pc", oPC, 32'h800);
    chk("call.ret", oRetAddr, 32'h204);
    chk("call.tmp", oPC_tmp, 32'h204);
    op("ret", 1, RET, 0, 0, 0);
    chk("ret.pc", oPC, 32'h204);
    chk("ret.empty", 32'(oEmpty), 32'd1);

    // Negative branch and address wrap
    op("jmp1000", 1, JUMP, 32'h1000, 0, 0);
    op("branch", 1, BRANCH, 0, 32'hFFFF_FFF0, 0);
    chk("branch.pc", oPC, 32'hFF0);
    chk("branch.tmp", oPC_tmp, 32'hFF0);
    op("jmp_top", 1, JUMP, 32'hFFFF_FFFC, 0, 0);
    op("wrap", 1, INC, 0, 0, 0);
    chk("wrap.pc", oPC, 32'h0);
    chk("wrap.ovf", 32'(oOverflow), 32'd0);

    // Nested calls past capacity, then drain and underflow
    op("jmp10", 1, JUMP, 32'h10, 0, 0);
    for (int i = 1; i <= 5; i++) op("nest", 1, CALL, 32'(16 * (i + 1)), 0, 0);
    chk("nest.full", 32'(oFull), 32'd1);
    chk("nest.ovf", 32'(oOverflow), 32'd1);
    op("pop1", 1, RET, 0, 0, 0);
    chk("pop1.pc", oPC, 32'h54);
    op("pop2", 1, RET, 0, 0, 0);
    chk("pop2.pc", oPC, 32'h44);
    op("pop3", 1, RET, 0, 0, 0);
    chk("pop3.pc", oPC, 32'h34);
    op("pop4", 1, RET, 0, 0, 0);
    chk("pop4.pc", oPC, 32'h24);
    op("jmp600", 1, JUMP, 32'h600, 0, 0);
    op("underflow", 1, RET, 0, 0, 0);
    chk("underflow.pc", oPC, 32'h604);
    chk("underflow.flag", 32'(oUnderflow), 32'd1);
    chk("underflow.depth", 32'(oDepth), 32'd0);

    // Enable low holds everything; clear still acts
    op("pre_hold", 1, CALL, 32'h900, 0, 0);
    saved_pc    = oPC;
    saved_ret   = oRetAddr;
    saved_depth = oDepth;
    for (int i = 0; i < 3; i++) op("hold", 0, CALL, 32'hABC0, 32'h8, 0);
    chk("hold.pc", oPC, saved_pc);
    chk("hold.ret", oRetAddr, saved_ret);
    chk("hold.depth", 32'(oDepth), 32'(saved_depth));
    op("clr_dis", 0, INC, 0, 0, 1);
    chk("clr_dis.ovf", 32'(oOverflow), 32'd0);
    chk("clr_dis.unf", 32'(oUnderflow), 32'd0);

    // Set beats clear; relative call
    op("drain", 1, RET, 0, 0, 0);
    op("set_wins", 1, RET, 0, 0, 1);
    chk("set_wins.unf", 32'(oUnderflow), 32'd1);
    op("jmp300", 1, JUMP, 32'h300, 0, 0);
    op("callrel", 1, CALLREL, 0, 32'h40, 0);
    chk("callrel.pc", oPC, 32'h340);
    chk("callrel.ret", oRetAddr, 32'h304);

    // Randomized operations, biased toward calls/returns
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  m;
      logic [31:0] ld, of;
      m  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) m = ($urandom_range(0, 1) == 0) ? CALL : RET;
      ld = $urandom;
      of = $urandom;
      op("rand", ($urandom_range(0, 9) != 0), m, ld, of, ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
